// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with TX FIFO, sticky overflow
//            flag and programmable baud divisor. Registers (addr[3:2]):
//            0 DATA (write pushes byte), 1 STATUS, 2 DIV, 3 reserved.
// Config   : UART_TX_FIFO_EN defined   -> FIFO of FIFO_DEPTH entries
//            UART_TX_FIFO_EN undefined -> single holding byte
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx
);

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_DIV    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;
    logic [15:0] r_baud;
    logic [15:0] r_div;
    logic        r_ovf;
    logic [4:0]  r_count;
    logic        r_tx;

    logic        w_wr_data;
    logic        w_wr_status;
    logic        w_wr_div;
    logic        w_pop;
    logic        w_accept;
    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic        w_bit_end;
    logic [7:0]  w_head;
    logic [15:0] w_div_eff;
    logic        w_unused;

    assign w_wr_data   = ce & we & (addr[3:2] == c_REG_DATA) & sel[0];
    assign w_wr_status = ce & we & (addr[3:2] == c_REG_STATUS);
    assign w_wr_div    = ce & we & (addr[3:2] == c_REG_DIV);

`ifdef UART_TX_FIFO_EN
    localparam int         c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [4:0] c_DEPTH_CNT = 5'(FIFO_DEPTH);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    // FIFO storage: written on every accepted push, contents need no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= data_i[7:0];
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
    end

    assign w_head = r_mem[r_rd_ptr];
`else
    localparam logic [4:0] c_DEPTH_CNT          = 5'd1;
    localparam int         c_UNUSED_FIFO_DEPTH  = FIFO_DEPTH;

    logic [7:0] r_hold;

    // Single holding byte; a push coincident with a pop replaces the old byte
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= data_i[7:0];
        end
    end

    assign w_head = r_hold;
`endif

    assign w_empty   = (r_count == 5'd0);
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_busy    = (r_state != S_IDLE);
    assign w_bit_end = (r_baud == 16'd0);
    assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
    // Head leaves the FIFO when idle or when the stop bit of a frame ends
    assign w_pop     = !w_empty && ((r_state == S_IDLE) ||
                                    ((r_state == S_STOP) && w_bit_end));
    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    assign w_accept  = w_wr_data && (!w_full || w_pop);
    assign w_unused  = ^{addr[31:4], addr[1:0], data_i[31:16]};

    // Occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 5'd0;
        end else begin
            r_count <= r_count + {4'd0, w_accept} - {4'd0, w_pop};
        end
    end

    // Sticky overflow flag and baud divisor register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_div <= DIV_RESET;
        end else begin
            if (w_wr_data && !w_accept) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && sel[0] && data_i[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_div && sel[0]) r_div[7:0]  <= data_i[7:0];
            if (w_wr_div && sel[1]) r_div[15:8] <= data_i[15:8];
        end
    end

    // Serializer: each bit period is sampled from the divisor at its start,
    // so a divisor change only affects the next bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_shift  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_baud   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= w_head;
                        r_baud  <= w_div_eff - 16'd1;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state  <= S_DATA;
                        r_tx     <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitcnt <= 3'd0;
                        r_baud   <= w_div_eff - 16'd1;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= w_div_eff - 16'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx     <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_state <= S_START;
                            r_shift <= w_head;
                            r_baud  <= w_div_eff - 16'd1;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Read mux: only active bus reads return data
    always_comb begin
        data_o = 32'd0;
        if (ce && !we) begin
            case (addr[3:2])
                c_REG_STATUS: data_o = {24'd0, r_count[3:0], r_ovf, w_empty, w_full, w_busy};
                c_REG_DIV:    data_o = {16'd0, r_div};
                default:      data_o = 32'd0;
            endcase
        end
    end

    assign tx = r_tx;

endmodule
`default_nettype wire
